// File: rtl/jts16_trackball_rd.sv
// CPU-side readout of the eight 12-bit trackball counters.
// Each channel is read as a byte-wide pair of registers. Each channel has:
//   - a CPU-settable zero point (base)
//   - a low-read snapshot, so the following high read returns the same sample
//   - a sticky "moved" flag, shown in bit 7 of the high byte
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   trackball0..7_i   absolute counters from the accumulator (wrap mod 4096)
//   cs_i              access strobe (level); one access per rising edge
//   rnw_i             1 = read, 0 = write
//   addr_i            [3:1] channel, [0] 0 = low byte, 1 = high byte
//   din_i             write data; bit 0 enables the global clear on a high-byte write
//   dout_o            registered read data, held until the next read access
module jts16_trackball_rd (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] trackball0_i,
  input  logic [11:0] trackball1_i,
  input  logic [11:0] trackball2_i,
  input  logic [11:0] trackball3_i,
  input  logic [11:0] trackball4_i,
  input  logic [11:0] trackball5_i,
  input  logic [11:0] trackball6_i,
  input  logic [11:0] trackball7_i,
  input  logic        cs_i,
  input  logic        rnw_i,
  input  logic [3:0]  addr_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o
);

  logic [7:0][11:0] tb;
  logic [7:0][11:0] rel;
  logic [7:0][11:0] base_q, base_d;
  logic [7:0][11:0] snap_q, snap_d;
  logic [7:0][11:0] prev_q;
  logic [7:0]       latched_q, latched_d;
  logic [7:0]       moved_q, moved_d;
  logic [7:0]       dout_q, dout_d;
  logic             primed_q, csl_q;

  logic       access, rd_lo, rd_hi, wr_lo, wr_all;
  logic [2:0] ch;
  logic       sel, zero, changed;
  logic [11:0] hi_val;

  assign tb = {trackball7_i, trackball6_i, trackball5_i, trackball4_i,
               trackball3_i, trackball2_i, trackball1_i, trackball0_i};

  always_comb begin
    // The priming cycle after reset never counts as an access, so a cs held
    // high through reset release is ignored.
    access  = cs_i & ~csl_q & primed_q;
    ch      = addr_i[3:1];
    rd_lo   = access &  rnw_i & ~addr_i[0];
    rd_hi   = access &  rnw_i &  addr_i[0];
    wr_lo   = access & ~rnw_i & ~addr_i[0];
    wr_all  = access & ~rnw_i &  addr_i[0] & din_i[0];

    base_d    = base_q;
    snap_d    = snap_q;
    latched_d = latched_q;
    moved_d   = moved_q;
    sel       = 1'b0;
    zero      = 1'b0;
    changed   = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      rel[i]  = tb[i] - base_q[i];
      sel     = (ch == i[2:0]);
      zero    = (wr_lo & sel) | wr_all;
      changed = primed_q & (tb[i] != prev_q[i]);

      if (zero) base_d[i] = tb[i];
      if (rd_lo & sel) snap_d[i] = rel[i];

      if (zero || (rd_hi && sel)) latched_d[i] = 1'b0;
      else if (rd_lo && sel)      latched_d[i] = 1'b1;

      // Zeroing beats a same-cycle move; a move beats the high-read clear.
      if (zero)                  moved_d[i] = 1'b0;
      else if (changed)          moved_d[i] = 1'b1;
      else if (rd_hi && sel)     moved_d[i] = 1'b0;
    end

    hi_val = latched_q[ch] ? snap_q[ch] : rel[ch];
    dout_d = dout_q;
    if (rd_lo)      dout_d = rel[ch][7:0];
    else if (rd_hi) dout_d = {moved_q[ch], 3'b000, hi_val[11:8]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      snap_q    <= '0;
      prev_q    <= '0;
      latched_q <= '0;
      moved_q   <= '0;
      dout_q    <= '0;
      primed_q  <= 1'b0;
      csl_q     <= 1'b0;
    end else begin
      base_q    <= base_d;
      snap_q    <= snap_d;
      prev_q    <= tb;
      latched_q <= latched_d;
      moved_q   <= moved_d;
      dout_q    <= dout_d;
      primed_q  <= 1'b1;
      csl_q     <= cs_i;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: tb/tb_jts16_trackball_rd.sv
module tb_jts16_trackball_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] tb0 = 12'h10A, tb1 = 12'h2FF, tb2 = 12'h30C, tb3 = 12'h005;
  logic [11:0] tb4 = 12'h040, tb5 = 12'h050, tb6 = 12'h060, tb7 = 12'h070;
  logic        cs = 1'b0, rnw = 1'b1;
  logic [3:0]  addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jts16_trackball_rd dut (
    .clk          (clk),
    .rst          (rst),
    .trackball0_i (tb0),
    .trackball1_i (tb1),
    .trackball2_i (tb2),
    .trackball3_i (tb3),
    .trackball4_i (tb4),
    .trackball5_i (tb5),
    .trackball6_i (tb6),
    .trackball7_i (tb7),
    .cs_i         (cs),
    .rnw_i        (rnw),
    .addr_i       (addr),
    .din_i        (din),
    .dout_o       (dout)
  );

  task automatic check(input string tag, input logic [7:0] exp);
    total++;
    assert (dout === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, dout, exp);
    end
  endtask

  // One access: cs rises at a negedge, the DUT sees it on the next posedge.
  task automatic access(input logic r, input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rnw = r; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    access(1'b1, a, 8'h00);
    check(tag, exp);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    access(1'b0, a, d);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dout", 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values do not set moved after priming.
    rd(4'd0, 8'h0A, "ch0_lo");
    rd(4'd1, 8'h01, "ch0_hi");

    // Snapshot coherence.
    rd(4'd2, 8'hFF, "ch1_lo");
    tb1 = 12'h300;
    repeat (2) @(negedge clk);
    rd(4'd3, 8'h82, "ch1_hi_snap");
    rd(4'd3, 8'h03, "ch1_hi_live");

    // Zero point.
    wr(4'd4, 8'h00);
    rd(4'd4, 8'h00, "ch2_zero_lo");
    rd(4'd5, 8'h00, "ch2_zero_hi");
    tb2 = 12'h310;
    @(negedge clk);
    rd(4'd4, 8'h04, "ch2_delta_lo");

    // Wrap-around: base 0x005, counter 0x003 -> rel 0xFFE.
    wr(4'd6, 8'h00);
    tb3 = 12'h003;
    repeat (2) @(negedge clk);
    rd(4'd6, 8'hFE, "ch3_wrap_lo");
    rd(4'd7, 8'h8F, "ch3_wrap_hi");

    // Global clear.
    wr(4'd1, 8'h01);
    for (int c = 0; c < 8; c++) begin
      rd(4'(2 * c), 8'h00, $sformatf("clr_ch%0d_lo", c));
      rd(4'(2 * c + 1), 8'h00, $sformatf("clr_ch%0d_hi", c));
    end

    // High write with din[0]=0 must not zero.
    tb5 = 12'h173;
    @(negedge clk);
    wr(4'd1, 8'h00);
    rd(4'd10, 8'h23, "noclr_ch5_lo");
    rd(4'd11, 8'h81, "noclr_ch5_hi");

    // Held cs: single access, single snapshot.
    tb6 = 12'h15F;
    @(negedge clk);
    cs = 1'b1; rnw = 1'b1; addr = 4'd12;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tb6 = 12'h170 + 12'(k);
      if (k == 0) check("held_first", 8'hFF);
    end
    check("held_last", 8'hFF);
    cs = 1'b0;
    @(negedge clk);
    rd(4'd13, 8'h80, "held_hi_snap");

    // Reset in the middle of an access with cs held through release.
    cs = 1'b1; rnw = 1'b1; addr = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_dout", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("cs_held_no_access", 8'h00);
    cs = 1'b0;
    @(negedge clk);
    rd(4'd0, 8'h0A, "post_rst_lo");
    rd(4'd1, 8'h01, "post_rst_hi");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jts16_trackball_rd.md
# jts16_trackball_rd

CPU-side readout stage for the trackball counters: consumes the eight 12-bit absolute counters produced by the trackball accumulator and presents them to the main CPU as byte-wide registers. Each channel has a CPU-settable zero point, a coherent low/high byte snapshot and a sticky "moved" flag. The block sits between the trackball accumulator and the I/O chip-select decoding of the main CPU bus.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- trackball0..trackball7  in  12 each  absolute counters from the accumulator, free-running, wrap mod 4096
- cs  in  1  access strobe from the I/O decoder, level; one access per rising edge
- rnw  in  1  1 = read, 0 = write; sampled with the cs rising edge
- addr  in  4  addr[3:1] = channel 0..7; addr[0] = 0 low byte, 1 high byte
- din  in  8  write data; bit 0 used only by the global clear
- dout  out  8  registered read data, held until the next read access

## Operation
- Relative value per channel: rel[ch] = trackball[ch] − base[ch], 12-bit, mod 4096 (no saturation).
- An access is the cycle where cs=1 and the previous-cycle cs=0. Holding cs high does not retrigger.
- Read low byte (addr[0]=0): snap[ch] <= rel[ch]; latched[ch] <= 1; dout <= rel[ch][7:0].
- Read high byte (addr[0]=1): value = latched[ch] ? snap[ch] : rel[ch]; dout <= {moved[ch], 3'b000, value[11:8]}; latched[ch] <= 0; moved[ch] <= 0.
- Write low byte: base[ch] <= trackball[ch] (rel becomes 0); latched[ch] <= 0; moved[ch] <= 0.
- Write high byte with din[0]=1: applies the low-byte write action to all eight channels at once. din[0]=0: no effect.
- Moved flag: prev[ch] registers trackball[ch] every cycle; moved[ch] is set when trackball[ch] ≠ prev[ch].
- Priming: on the first clock after reset, prev is loaded and moved is not set. This keeps the non-zero accumulator reset values from setting the flags.
- Simultaneous events: a moved set and a high-read clear in the same cycle leave moved=1. A write-zero and a counter change in the same cycle give base = new counter value, with moved cleared and then set on the next compare only if the value changes again.

## Timing
- Reset values: dout=0, base[*]=0, snap[*]=0, latched[*]=0, moved[*]=0, prev[*]=0, primed=0, csl=0.
- Read latency: dout is updated on the clk edge that detects the cs rise and is valid from the next cycle.
- Write effects are visible to a read whose cs edge comes one or more cycles later.
- A trackball change at edge N sets moved at edge N+1 (one-cycle compare latency).
- Reset mid-access: all state returns to reset values. A cs held high through reset deassertion is not treated as an access, because csl is cleared and the first cycle only primes.
- Snapshot coherence: between a low read and the matching high read, counter changes do not affect the returned high nibble.

## Test plan
- Reset with accumulator reset values (tb0=0x10A). Read ch0 low -> 0x0A, then high -> 0x01, with bit7=0 because no move occurred after priming.
- Coherence: read ch1 low (tb1=0x2FF) -> 0xFF. Change tb1 to 0x300, then read ch1 high -> 0x82 (snapshot nibble 2, moved=1). Read high again -> 0x03 (live value, moved cleared).
- Zero point: write ch2 low with tb2=0x30C. Read ch2 low -> 0x00, high -> 0x00. Set tb2=0x310, then read low -> 0x04.
- Wrap-around: base3=0x005 and tb3=0x003 give rel 0xFFE. Read low -> 0xFE, high -> 0x8F.
- Global clear: write addr=1 with din=0x01. All channels then read low 0x00 and high 0x00. The same write with din=0x00 leaves all values unchanged.
- Held cs: keep cs high for 10 cycles on a low read while tb changes. dout does not update, and only one snapshot is taken.
